bit_serial_alu_seq: RTL

Bit-serial sequencer that drives a one-bit ALU slice. It accepts a WIDTH-bit operation, then presents operand bits LSB-first to the slice's OP/A/B/Cin inputs, one bit per clock. It registers the slice's RES/Cout on every cycle, chains the carry, and reassembles the WIDTH-bit result with flags. It sits between the register/control logic and a single combinational bit slice, replacing a WIDTH-slice ripple array.

---
 rtl/bit_serial_alu_seq.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/bit_serial_alu_seq.sv
// ---------------------------------------------------------------------------
// bit_serial_alu_seq
//
// Sequencer that drives a single combinational one-bit ALU slice. An accepted
// WIDTH-bit operation is presented to the slice one bit per clock, LSB first.
// The slice's carry-out is chained back in as the next bit's carry-in, and the
// WIDTH-bit result is reassembled together with carry/zero/overflow flags.
//
// Ports
//   clk, rst_n     clock; synchronous active-low reset
//   start          operation request, honoured only when busy=0
//   OP_IN/A_IN/B_IN opcode and operands, captured on an accepted start
//   busy           high while operand bits are being sequenced
//   done           one-cycle pulse, RESULT and flags valid
//   RESULT         assembled result, held until the next accepted start
//   CARRY/ZERO/OVF carry out of MSB, result==0, signed overflow (ADD/SUB)
//   OP/A/B/Cin     to slice: opcode, current operand bits, carry in
//   RES/Cout       from slice: result bit and carry out of the current bit
// ---------------------------------------------------------------------------
module bit_serial_alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       OP_IN,
    input  logic [WIDTH-1:0] A_IN,
    input  logic [WIDTH-1:0] B_IN,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] RESULT,
    output logic             CARRY,
    output logic             ZERO,
    output logic             OVF,
    output logic [3:0]       OP,
    output logic             A,
    output logic             B,
    output logic             Cin,
    input  logic             RES,
    input  logic             Cout
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state_q,      state_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [3:0]       op_q,         op_d;
    logic [WIDTH-1:0] a_q,          a_d;
    logic [WIDTH-1:0] b_q,          b_d;
    logic             carry_q,      carry_d;
    logic [WIDTH-1:0] result_q,     result_d;
    logic             carry_flag_q, carry_flag_d;
    logic             zero_q,       zero_d;
    logic             ovf_q,        ovf_d;

    logic             in_shift;
    logic             accept;
    logic             is_arith;
    logic [WIDTH-1:0] result_next;

    assign in_shift = (state_q == ST_SHIFT);
    assign accept   = start && !in_shift;
    assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);

    // The slice's result bit enters from the MSB side, so after WIDTH shifts
    // bit 0 of the operation has landed in bit 0 of the result register.
    assign result_next = {RES, result_q[WIDTH-1:1]};

    always_comb begin
        // NOTE: every _d takes its _q value first, so paths that do not
        // assign a signal hold state instead of inferring a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        carry_d      = carry_q;
        result_d     = result_q;
        carry_flag_d = carry_flag_q;
        zero_d       = zero_q;
        ovf_d        = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                // Operand registers shift right so the current bit is always
                // at position 0; the carry register follows the slice.
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                result_d = result_next;
                carry_d  = Cout;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    state_d      = ST_DONE;
                    cnt_d        = '0;
                    carry_flag_d = Cout;
                    zero_d       = (result_next == '0);
                    // carry_q is the carry into the MSB during this bit.
                    ovf_d        = is_arith && (carry_q ^ Cout);
                end
            end
            ST_DONE: begin
                state_d = start ? ST_SHIFT : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new operation can only begin outside SHIFT, so this never
        // collides with the bit-shifting updates above.
        if (accept) begin
            op_d     = OP_IN;
            a_d      = A_IN;
            b_d      = B_IN;
            result_d = '0;
            cnt_d    = '0;
            carry_d  = (OP_IN == OP_SUB);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            carry_q      <= 1'b0;
            result_q     <= '0;
            carry_flag_q <= 1'b0;
            zero_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            carry_q      <= carry_d;
            result_q     <= result_d;
            carry_flag_q <= carry_flag_d;
            zero_q       <= zero_d;
            ovf_q        <= ovf_d;
        end
    end

    assign busy   = in_shift;
    assign done   = (state_q == ST_DONE);
    assign RESULT = result_q;
    assign CARRY  = carry_flag_q;
    assign ZERO   = zero_q;
    assign OVF    = ovf_q;

    // Slice operand/carry inputs are forced low outside SHIFT; the opcode
    // keeps showing the last captured operation.
    assign OP  = op_q;
    assign A   = in_shift & a_q[0];
    assign B   = in_shift & b_q[0];
    assign Cin = in_shift & carry_q;

endmodule
